// File: rtl/pipeline_alu_fwd.sv
// Four-stage pipelined ALU: S1 operand fetch, S2 execute, S3 regbank writeback/output, S4 memory store.
// Operand forwarding from S2 into both S1 capture and S2 execute removes all dependency stalls.
module pipeline_alu_fwd #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned MEM_AW = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [$clog2(NREG)-1:0]   rs1,
  input  logic [$clog2(NREG)-1:0]   rs2,
  input  logic [$clog2(NREG)-1:0]   rd,
  input  logic [3:0]                func,
  input  logic [MEM_AW-1:0]         addr,
  output logic [DATA_W-1:0]         z_out,
  output logic                      z_valid,
  output logic                      z_carry,
  output logic                      z_zero,
  output logic                      z_err,
  input  logic [MEM_AW-1:0]         mem_raddr,
  output logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned RW    = $clog2(NREG);
  localparam int unsigned DEPTH = 1 << MEM_AW;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_A   = 4'd3;
  localparam logic [3:0] OP_B   = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7;
  localparam logic [3:0] OP_NA  = 4'd8,  OP_NB  = 4'd9,  OP_SRL = 4'd10, OP_SLL = 4'd11;
  localparam logic [3:0] OP_LDI = 4'd12, OP_SRA = 4'd13, OP_SLT = 4'd14;

  // S1: fetched instruction and operands
  logic              s1_valid_q, s1_valid_d;
  logic [RW-1:0]     s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d, s1_rd_q, s1_rd_d;
  logic [3:0]        s1_func_q, s1_func_d;
  logic [MEM_AW-1:0] s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

  // S2: executed result
  logic              s2_valid_q, s2_valid_d;
  logic [RW-1:0]     s2_rd_q, s2_rd_d;
  logic              s2_err_q, s2_err_d;
  logic              s2_carry_q, s2_carry_d;
  logic [DATA_W-1:0] s2_res_q, s2_res_d;
  logic [MEM_AW-1:0] s2_addr_q, s2_addr_d;

  // S3: retiring result, drives the outputs
  logic              z_valid_q, z_valid_d;
  logic [DATA_W-1:0] z_out_q, z_out_d;
  logic              z_carry_q, z_carry_d;
  logic              z_zero_q, z_zero_d;
  logic              z_err_q, z_err_d;
  logic [MEM_AW-1:0] s3_addr_q, s3_addr_d;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_we;

  logic              fwd_ok;
  logic [DATA_W-1:0] ea, eb, res;
  logic [DATA_W:0]   sum;
  logic              carry, err;

  always_comb begin
    fwd_ok = s2_valid_q && !s2_err_q;

    s1_valid_d = in_valid;
    s1_rs1_d   = rs1;
    s1_rs2_d   = rs2;
    s1_rd_d    = rd;
    s1_func_d  = func;
    s1_addr_d  = addr;
    s1_a_d     = (fwd_ok && s2_rd_q == rs1) ? s2_res_q : regs_q[rs1];
    s1_b_d     = (fwd_ok && s2_rd_q == rs2) ? s2_res_q : regs_q[rs2];

    // S2 holds the newest producer, so it overrides the operand fetched one cycle earlier
    ea = (fwd_ok && s2_rd_q == s1_rs1_q) ? s2_res_q : s1_a_q;
    eb = (fwd_ok && s2_rd_q == s1_rs2_q) ? s2_res_q : s1_b_q;

    sum   = '0;
    res   = '0;
    carry = 1'b0;
    err   = 1'b0;
    case (s1_func_q)
      OP_ADD: begin
        sum   = {1'b0, ea} + {1'b0, eb};
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        res   = ea - eb;
        carry = ea < eb;
      end
      OP_MUL:  res = ea * eb;
      OP_A:    res = ea;
      OP_B:    res = eb;
      OP_AND:  res = ea & eb;
      OP_OR:   res = ea | eb;
      OP_XOR:  res = ea ^ eb;
      OP_NA:   res = ~ea;
      OP_NB:   res = ~eb;
      OP_SRL:  res = ea >> 1;
      OP_SLL:  res = ea << 1;
      OP_LDI:  res = DATA_W'(s1_addr_q);
      OP_SRA:  res = DATA_W'($signed(ea) >>> 1);
      OP_SLT:  res = DATA_W'($signed(ea) < $signed(eb));
      default: err = 1'b1;
    endcase

    s2_valid_d = s1_valid_q;
    s2_rd_d    = s1_rd_q;
    s2_addr_d  = s1_addr_q;
    s2_err_d   = s1_valid_q && err;
    s2_carry_d = s1_valid_q && carry;
    s2_res_d   = s1_valid_q ? res : '0;

    z_valid_d = s2_valid_q;
    z_out_d   = s2_res_q;
    z_carry_d = s2_valid_q && s2_carry_q;
    z_zero_d  = s2_valid_q && (s2_res_q == '0);
    z_err_d   = s2_valid_q && s2_err_q;
    s3_addr_d = s2_addr_q;

    regs_d = regs_q;
    if (fwd_ok) regs_d[s2_rd_q] = s2_res_q;

    mem_we      = z_valid_q && !z_err_q;
    mem_rdata_d = mem_q[mem_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_rd_q     <= '0;
      s1_func_q   <= '0;
      s1_addr_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_rd_q     <= '0;
      s2_err_q    <= 1'b0;
      s2_carry_q  <= 1'b0;
      s2_res_q    <= '0;
      s2_addr_q   <= '0;
      z_valid_q   <= 1'b0;
      z_out_q     <= '0;
      z_carry_q   <= 1'b0;
      z_zero_q    <= 1'b0;
      z_err_q     <= 1'b0;
      s3_addr_q   <= '0;
      regs_q      <= '{default: '0};
      mem_rdata_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_rd_q     <= s1_rd_d;
      s1_func_q   <= s1_func_d;
      s1_addr_q   <= s1_addr_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_rd_q     <= s2_rd_d;
      s2_err_q    <= s2_err_d;
      s2_carry_q  <= s2_carry_d;
      s2_res_q    <= s2_res_d;
      s2_addr_q   <= s2_addr_d;
      z_valid_q   <= z_valid_d;
      z_out_q     <= z_out_d;
      z_carry_q   <= z_carry_d;
      z_zero_q    <= z_zero_d;
      z_err_q     <= z_err_d;
      s3_addr_q   <= s3_addr_d;
      regs_q      <= regs_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Data memory contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[s3_addr_q] <= z_out_q;
  end

  assign z_out     = z_out_q;
  assign z_valid   = z_valid_q;
  assign z_carry   = z_carry_q;
  assign z_zero    = z_zero_q;
  assign z_err     = z_err_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_pipeline_alu_fwd.sv
// Scoreboard bench for pipeline_alu_fwd: a sequential ISA model predicts every S3 output cycle
// and the memory contents seen through the read port.
module tb_pipeline_alu_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, mem_raddr;
  logic [15:0] z_out, mem_rdata;
  logic        z_valid, z_carry, z_zero, z_err;

  always #5 clk = ~clk;

  pipeline_alu_fwd #(.DATA_W(16), .NREG(16), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .z_out(z_out), .z_valid(z_valid), .z_carry(z_carry),
    .z_zero(z_zero), .z_err(z_err), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] z;
    logic        c;
    logic        zr;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] regs_m [16];
  logic [15:0] mem_m    [int];
  logic [15:0] mem_snap [int];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void alu_model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                    input logic [7:0] imm, output logic [15:0] r,
                                    output logic c, output logic e);
    int unsigned s;
    r = 16'h0; c = 1'b0; e = 1'b0;
    case (f)
      4'd0:  begin s = int'(a) + int'(b); r = s[15:0]; c = s[16]; end
      4'd1:  begin r = 16'(int'(a) - int'(b)); c = (int'(a) < int'(b)); end
      4'd2:  begin s = int'(a) * int'(b); r = s[15:0]; end
      4'd3:  r = a;
      4'd4:  r = b;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = 16'hFFFF - a;
      4'd9:  r = 16'hFFFF - b;
      4'd10: r = {1'b0, a[15:1]};
      4'd11: r = {a[14:0], 1'b0};
      4'd12: r = {8'h00, imm};
      4'd13: r = {a[15], a[15:1]};
      4'd14: r = ((a ^ 16'h8000) < (b ^ 16'h8000)) ? 16'd1 : 16'd0;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic compare_out();
    exp_t x;
    x = sb.pop_front();
    check("z_valid", z_valid, x.v);
    if (x.v) begin
      check("z_out", z_out, x.z);
      check("z_carry", z_carry, x.c);
      check("z_zero", z_zero, x.zr);
      check("z_err", z_err, x.e);
    end else begin
      check("z_zero_idle", z_zero, 1'b0);
    end
  endtask

  task automatic issue(input logic v, input logic [3:0] f, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [7:0] a);
    exp_t        x;
    logic [15:0] r;
    logic        c, e;
    in_valid = v; func = f; rd = d; rs1 = s1; rs2 = s2; addr = a;
    x = '0;
    if (v) begin
      alu_model(f, regs_m[s1], regs_m[s2], a, r, c, e);
      x = '{v: 1'b1, z: r, c: c, zr: (r == 16'h0), e: e};
      if (!e) begin
        regs_m[d] = r;
        mem_m[int'(a)] = r;
      end
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() > 2) compare_out();
  endtask

  task automatic bubble();
    issue(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
  endtask

  task automatic drain();
    repeat (3) bubble();
  endtask

  task automatic ldi(input logic [3:0] d, input logic [7:0] imm);
    issue(1'b1, 4'd12, d, 4'd0, 4'd0, imm);
  endtask

  task automatic rd_mem(input logic [7:0] a);
    mem_raddr = a;
    bubble();
    check($sformatf("mem[%0h]", a), mem_rdata, mem_m[int'(a)]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1; func = 4'd12; rd = 4'd5; rs1 = 4'd0; rs2 = 4'd0; addr = 8'h33;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_z_valid", z_valid, 1'b0);
    check("rst_z_out", z_out, 16'h0);
    check("rst_z_carry", z_carry, 1'b0);
    check("rst_z_zero", z_zero, 1'b0);
    check("rst_z_err", z_err, 1'b0);
    check("rst_mem_rdata", mem_rdata, 16'h0);
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    for (int i = 0; i < 16; i++) regs_m[i] = 16'h0;
  endtask

  initial begin
    mem_raddr = 8'h00;
    for (int i = 0; i < 16; i++) regs_m[i] = 16'h0;
    rst = 1'b1;
    @(posedge clk);
    do_reset();

    // LDI to the top address, then read it back through the check port
    ldi(4'd1, 8'hFF);
    drain();
    rd_mem(8'hFF);

    // Both forwarding paths: S2 execute and S1 capture
    ldi(4'd1, 8'd5);
    ldi(4'd2, 8'd3);
    issue(1'b1, 4'd1, 4'd3, 4'd1, 4'd2, 8'h20);
    issue(1'b1, 4'd1, 4'd4, 4'd2, 4'd1, 8'h21);

    // 0xFFFF + 1 wraps to zero with carry
    ldi(4'd1, 8'hFF);
    ldi(4'd2, 8'hFF);
    repeat (8) issue(1'b1, 4'd11, 4'd2, 4'd2, 4'd0, 8'h22);
    issue(1'b1, 4'd6, 4'd1, 4'd1, 4'd2, 8'h23);
    ldi(4'd2, 8'd1);
    issue(1'b1, 4'd0, 4'd3, 4'd1, 4'd2, 8'h24);

    // Back-to-back self-dependent chain
    ldi(4'd1, 8'd1);
    repeat (4) issue(1'b1, 4'd0, 4'd1, 4'd1, 4'd1, 8'h25);

    // Illegal opcode: no register or memory write
    ldi(4'd1, 8'd7);
    ldi(4'd5, 8'h50);
    issue(1'b1, 4'd15, 4'd1, 4'd1, 4'd1, 8'h50);
    issue(1'b1, 4'd3, 4'd6, 4'd1, 4'd0, 8'h26);
    drain();
    rd_mem(8'h50);
    rd_mem(8'h20);
    rd_mem(8'h21);
    rd_mem(8'h24);

    // Random mix with bubbles; all opcodes and dense register dependencies
    for (int i = 0; i < 60; i++) begin
      issue(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 8'($urandom_range(8'h80, 8'h8F)));
    end
    drain();
    for (int a = 8'h80; a <= 8'h8F; a++) if (mem_m.exists(a)) rd_mem(8'(a));

    // Reset with three instructions in flight
    ldi(4'd7, 8'h40);
    ldi(4'd7, 8'h41);
    ldi(4'd7, 8'h42);
    drain();
    mem_snap = mem_m;
    issue(1'b1, 4'd0, 4'd1, 4'd7, 4'd7, 8'h40);
    issue(1'b1, 4'd6, 4'd2, 4'd7, 4'd1, 8'h41);
    issue(1'b1, 4'd8, 4'd3, 4'd2, 4'd0, 8'h42);
    do_reset();
    mem_m = mem_snap;
    for (int r = 0; r < 16; r++) issue(1'b1, 4'd3, 4'd0, 4'(r), 4'd0, 8'h60);
    drain();
    rd_mem(8'h40);
    rd_mem(8'h41);
    rd_mem(8'h42);
    rd_mem(8'h60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
